// File: rtl/fusion_psum_accumulator_pkg.sv
// fusion_pkg: FSM state type and psum width shared with fusion_unit
package fusion_pkg;
    localparam int FUSION_PSUM_W = 16;
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
endpackage

// File: rtl/fusion_psum_accumulator_if.sv
// fusion_psum_accumulator_if: psum input stream, config and result handshake
interface fusion_psum_accumulator_if import fusion_pkg::*; #(
    parameter int PSUM_W = FUSION_PSUM_W,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 8
) ();
    logic [LEN_W-1:0]  cfg_len;
    logic              cfg_signed;
    logic              psum_valid;
    logic              psum_ready;
    logic [PSUM_W-1:0] psum_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              out_overflow;
    logic              busy;
    modport master (
        output cfg_len, cfg_signed, psum_valid, psum_data, out_ready,
        input  psum_ready, out_valid, out_data, out_overflow, busy
    );
    modport slave (
        input  cfg_len, cfg_signed, psum_valid, psum_data, out_ready,
        output psum_ready, out_valid, out_data, out_overflow, busy
    );
endinterface

// File: rtl/fusion_psum_ext_add.sv
// fusion_psum_ext_add: extend psum to ACC_W, add, detect overflow, wrap or clamp
module fusion_psum_ext_add import fusion_pkg::*; #(
    parameter int PSUM_W   = FUSION_PSUM_W,
    parameter int ACC_W    = 32,
    parameter int SATURATE = 0
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PSUM_W-1:0] psum,
    input  logic              sgn,
    input  logic              ovf_in,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);
    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] clamp;
    logic [ACC_W:0]   raw;
    always_comb begin
        ext   = sgn ? {{(ACC_W-PSUM_W){psum[PSUM_W-1]}}, psum} : {{(ACC_W-PSUM_W){1'b0}}, psum};
        raw   = {1'b0, acc} + {1'b0, ext};
        ovf   = sgn ? (acc[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]) : raw[ACC_W];
        clamp = !sgn ? '1 : acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        // once clamped, the accumulator stays pinned for the rest of the group
        sum   = (SATURATE == 0) ? raw[ACC_W-1:0] : ovf_in ? acc : ovf ? clamp : raw[ACC_W-1:0];
    end
endmodule

// File: rtl/fusion_psum_accumulator.sv
// fusion_psum_accumulator: sums cfg_len partial products per group, one result per group
module fusion_psum_accumulator import fusion_pkg::*; #(
    parameter int PSUM_W   = FUSION_PSUM_W,
    parameter int ACC_W    = 32,
    parameter int LEN_W    = 8,
    parameter int SATURATE = 0
) (
    input logic clk,
    input logic rst,
    fusion_psum_accumulator_if.slave bus
);
    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d, add_a, add_sum;
    logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
    logic             sgn_q, sgn_d, ovf_q, ovf_d;
    logic             first, xfer, add_sgn, add_ovf_in, add_ovf;
    // a psum accepted outside ACCUM always opens a new group, including from HOLD
    assign first          = state_q != ACCUM;
    assign bus.psum_ready = state_q != HOLD || bus.out_ready;
    assign xfer           = bus.psum_valid && bus.psum_ready;
    assign add_a          = first ? '0 : acc_q;
    assign add_sgn        = first ? bus.cfg_signed : sgn_q;
    assign add_ovf_in     = first ? 1'b0 : ovf_q;
    assign bus.out_valid    = state_q == HOLD;
    assign bus.out_data     = acc_q;
    assign bus.out_overflow = state_q == HOLD && ovf_q;
    assign bus.busy         = state_q != IDLE;
    fusion_psum_ext_add #(.PSUM_W(PSUM_W), .ACC_W(ACC_W), .SATURATE(SATURATE)) u_add (
        .acc(add_a), .psum(bus.psum_data), .sgn(add_sgn), .ovf_in(add_ovf_in),
        .sum(add_sum), .ovf(add_ovf)
    );
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sgn_d   = sgn_q;
        ovf_d   = ovf_q;
        if (xfer && first) begin
            len_d   = bus.cfg_len == '0 ? LEN_W'(1) : bus.cfg_len;
            sgn_d   = bus.cfg_signed;
            acc_d   = add_sum;
            cnt_d   = LEN_W'(1);
            ovf_d   = 1'b0;
            state_d = bus.cfg_len <= LEN_W'(1) ? HOLD : ACCUM;
        end else if (xfer) begin
            acc_d   = add_sum;
            cnt_d   = cnt_q + LEN_W'(1);
            ovf_d   = ovf_q | add_ovf;
            state_d = cnt_d == len_q ? HOLD : ACCUM;
        end else if (state_q == HOLD && bus.out_ready) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            sgn_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sgn_q   <= sgn_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_fusion_psum_accumulator.sv
// tb_fusion_psum_accumulator: directed vectors plus randomized scoreboard over 32-bit wrap, 20-bit wrap and 20-bit saturate instances
module tb_fusion_psum_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cfg_len = '0;
    logic        cfg_signed = 1'b0;
    logic        psum_valid = 1'b0;
    logic [15:0] psum_data = '0;
    logic        out_ready = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fusion_psum_accumulator_if #(.ACC_W(32)) im ();
    fusion_psum_accumulator_if #(.ACC_W(20)) iw ();
    fusion_psum_accumulator_if #(.ACC_W(20)) isat ();
    assign im.cfg_len = cfg_len;       assign iw.cfg_len = cfg_len;       assign isat.cfg_len = cfg_len;
    assign im.cfg_signed = cfg_signed; assign iw.cfg_signed = cfg_signed; assign isat.cfg_signed = cfg_signed;
    assign im.psum_valid = psum_valid; assign iw.psum_valid = psum_valid; assign isat.psum_valid = psum_valid;
    assign im.psum_data = psum_data;   assign iw.psum_data = psum_data;   assign isat.psum_data = psum_data;
    assign im.out_ready = out_ready;   assign iw.out_ready = out_ready;   assign isat.out_ready = out_ready;

    fusion_psum_accumulator #(.ACC_W(32), .SATURATE(0)) u_m (.clk(clk), .rst(rst), .bus(im));
    fusion_psum_accumulator #(.ACC_W(20), .SATURATE(0)) u_w (.clk(clk), .rst(rst), .bus(iw));
    fusion_psum_accumulator #(.ACC_W(20), .SATURATE(1)) u_s (.clk(clk), .rst(rst), .bus(isat));

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: true integer sum checked against the representable range after every add
    function automatic void group_result(input int w, input bit sat, input bit sgn, input logic [15:0] ps[$],
                                         output logic [63:0] data, output bit ovf);
        longint lo, hi, acc, m;
        bit clamped;
        m = longint'(1) << w;
        lo = sgn ? -(longint'(1) << (w - 1)) : 0;
        hi = sgn ? (longint'(1) << (w - 1)) - 1 : m - 1;
        acc = 0; ovf = 0; clamped = 0;
        foreach (ps[i]) begin
            if (!clamped) begin
                acc += sgn ? longint'($signed(ps[i])) : longint'(ps[i]);
                if (acc > hi || acc < lo) begin
                    ovf = 1;
                    if (sat) begin
                        acc = acc > hi ? hi : lo;
                        clamped = 1;
                    end else begin
                        acc = (((acc - lo) % m) + m) % m + lo;
                    end
                end
            end
        end
        data = 64'(acc) & 64'(m - 1);
    endfunction

    typedef struct {
        logic [63:0] dm, dw, ds;
        bit om, ow, os;
    } res_t;
    res_t exp_q[$];
    logic [15:0] gps[$];
    int glen;
    bit gsgn;
    bit gopen = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            gps.delete();
            gopen = 0;
        end else begin
            chk("sb_out_valid_m", 64'(im.out_valid), 64'(exp_q.size() != 0));
            chk("sb_out_valid_w", 64'(iw.out_valid), 64'(exp_q.size() != 0));
            chk("sb_out_valid_s", 64'(isat.out_valid), 64'(exp_q.size() != 0));
            chk("sb_psum_ready", 64'(im.psum_ready), 64'(exp_q.size() == 0 || out_ready));
            chk("sb_busy", 64'(im.busy), 64'(gopen || exp_q.size() != 0));
            if (im.out_valid && out_ready && exp_q.size() != 0) begin
                res_t e;
                e = exp_q.pop_front();
                chk("sb_data_m", 64'(im.out_data), e.dm);
                chk("sb_data_w", 64'(iw.out_data), e.dw);
                chk("sb_data_s", 64'(isat.out_data), e.ds);
                chk("sb_ovf_m", 64'(im.out_overflow), 64'(e.om));
                chk("sb_ovf_w", 64'(iw.out_overflow), 64'(e.ow));
                chk("sb_ovf_s", 64'(isat.out_overflow), 64'(e.os));
            end
            if (psum_valid && im.psum_ready) begin
                if (!gopen) begin
                    gopen = 1;
                    glen = cfg_len == 0 ? 1 : int'(cfg_len);
                    gsgn = cfg_signed;
                end
                gps.push_back(psum_data);
                if (gps.size() == glen) begin
                    res_t r;
                    group_result(32, 0, gsgn, gps, r.dm, r.om);
                    group_result(20, 0, gsgn, gps, r.dw, r.ow);
                    group_result(20, 1, gsgn, gps, r.ds, r.os);
                    exp_q.push_back(r);
                    gps.delete();
                    gopen = 0;
                end
            end
        end
    end

    task automatic push(input logic [7:0] l, input bit s, input logic [15:0] d);
        int t = 0;
        cfg_len = l; cfg_signed = s; psum_data = d; psum_valid = 1'b1;
        @(negedge clk);
        while (!im.psum_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++; errors++;
            $display("FAIL push_timeout actual=ready_low expected=ready_high");
        end
        @(posedge clk); #1;
        psum_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  len;
        bit          sgn;
        int          n;
        logic [15:0] ps;
        logic [31:0] dm;
        bit          om;
        logic [19:0] dw;
        bit          ow;
        logic [19:0] ds;
        bit          os;
    } vec_t;
    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'd4,  1'b0, 4,  16'd65025, 32'd260100,   1'b0, 20'd260100, 1'b0, 20'd260100, 1'b0};
        vecs[1] = '{8'd2,  1'b1, 2,  16'hC000,  32'hFFFF8000, 1'b0, 20'hF8000,  1'b0, 20'hF8000,  1'b0};
        vecs[2] = '{8'd2,  1'b0, 2,  16'hC000,  32'h00018000, 1'b0, 20'h18000,  1'b0, 20'h18000,  1'b0};
        vecs[3] = '{8'd17, 1'b0, 17, 16'hFFFF,  32'h0010FFEF, 1'b0, 20'h0FFEF,  1'b1, 20'hFFFFF,  1'b1};
        vecs[4] = '{8'd0,  1'b0, 1,  16'h0007,  32'd7,        1'b0, 20'd7,      1'b0, 20'd7,      1'b0};
        vecs[5] = '{8'd17, 1'b1, 17, 16'h8000,  32'hFFF78000, 1'b0, 20'h78000,  1'b1, 20'h80000,  1'b1};
        vecs[6] = '{8'd17, 1'b1, 17, 16'h7FFF,  32'h00087FEF, 1'b0, 20'h87FEF,  1'b1, 20'h7FFFF,  1'b1};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(im.out_valid), 64'd0);
        chk("rst_busy", 64'(im.busy), 64'd0);
        chk("rst_psum_ready", 64'(im.psum_ready), 64'd1);
        chk("rst_out_overflow", 64'(im.out_overflow), 64'd0);
        chk("rst_out_data", 64'(im.out_data), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        foreach (vecs[v]) begin
            for (int k = 0; k < vecs[v].n; k++) push(vecs[v].len, vecs[v].sgn, vecs[v].ps);
            @(negedge clk);
            chk($sformatf("vec%0d_latency", v), 64'(im.out_valid), 64'd1);
            chk($sformatf("vec%0d_data_m", v), 64'(im.out_data), 64'(vecs[v].dm));
            chk($sformatf("vec%0d_ovf_m", v), 64'(im.out_overflow), 64'(vecs[v].om));
            chk($sformatf("vec%0d_data_w", v), 64'(iw.out_data), 64'(vecs[v].dw));
            chk($sformatf("vec%0d_ovf_w", v), 64'(iw.out_overflow), 64'(vecs[v].ow));
            chk($sformatf("vec%0d_data_s", v), 64'(isat.out_data), 64'(vecs[v].ds));
            chk($sformatf("vec%0d_ovf_s", v), 64'(isat.out_overflow), 64'(vecs[v].os));
            @(posedge clk); #1;
        end
        // backpressure, then retire and accept next group on the same edge
        out_ready = 1'b0;
        push(8'd1, 1'b0, 16'd5);
        cfg_len = 8'd1; psum_data = 16'd9; psum_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_psum_ready", 64'(im.psum_ready), 64'd0);
            chk("bp_out_data", 64'(im.out_data), 64'd5);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 64'(im.psum_ready), 64'd1);
        @(posedge clk); #1;
        psum_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", 64'(im.out_valid), 64'd1);
        chk("bp_next_data", 64'(im.out_data), 64'd9);
        @(posedge clk); #1;
        // mid-group cfg_len change is ignored
        push(8'd3, 1'b0, 16'd1);
        push(8'd9, 1'b0, 16'd2);
        push(8'd9, 1'b0, 16'd3);
        @(negedge clk);
        chk("cfgchg_valid", 64'(im.out_valid), 64'd1);
        chk("cfgchg_data", 64'(im.out_data), 64'd6);
        @(posedge clk); #1;
        // reset mid-group discards partial sum
        push(8'd4, 1'b0, 16'd100);
        push(8'd4, 1'b0, 16'd100);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_out_valid", 64'(im.out_valid), 64'd0);
        chk("rstmid_busy", 64'(im.busy), 64'd0);
        chk("rstmid_psum_ready", 64'(im.psum_ready), 64'd1);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) push(8'd4, 1'b0, 16'd1);
        @(negedge clk);
        chk("rstmid_next_data", 64'(im.out_data), 64'd4);
        @(posedge clk); #1;
        // randomized traffic against the scoreboard
        for (int c = 0; c < 3000; c++) begin
            int sel;
            sel = int'($urandom_range(0, 3));
            psum_valid = $urandom_range(0, 3) != 0;
            psum_data = sel == 0 ? 16'hFFFF : sel == 1 ? 16'h8000 : sel == 2 ? 16'h7FFF : 16'($urandom);
            cfg_len = $urandom_range(0, 3) == 0 ? 8'($urandom_range(16, 22)) : 8'($urandom_range(0, 6));
            cfg_signed = 1'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            @(posedge clk); #1;
        end
        psum_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
